// File: rtl/codec_cfg_pkg.sv
// Shared types, default WM8731 register table and byte formatting for the
// codec configuration sequencer.
package codec_cfg_pkg;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        GAP,
        DONE,
        ERROR
    } state_t;

    typedef struct packed {
        logic [6:0] reg_addr;
        logic [8:0] reg_data;
    } cfg_word_t;

    // Reset, power, paths, format, sampling, headphone level, then activate.
    localparam cfg_word_t CFG_TABLE [0:15] = '{
        cfg_word_t'(16'h1E00),
        cfg_word_t'(16'h0C10),
        cfg_word_t'(16'h0812),
        cfg_word_t'(16'h0A00),
        cfg_word_t'(16'h0E0A),
        cfg_word_t'(16'h1000),
        cfg_word_t'(16'h0579),
        cfg_word_t'(16'h1201),
        cfg_word_t'(16'h0017),
        cfg_word_t'(16'h0217),
        cfg_word_t'(16'h0679),
        cfg_word_t'(16'h0C00),
        cfg_word_t'(16'h1201),
        cfg_word_t'(16'h1201),
        cfg_word_t'(16'h1201),
        cfg_word_t'(16'h1201)
    };

    function automatic logic [7:0] cfg_byte(input logic [6:0] dev_addr,
                                            input cfg_word_t  word,
                                            input logic [1:0] byte_sel);
        logic [7:0] result;
        case (byte_sel)
            2'd0:    result = {dev_addr, 1'b0};
            2'd1:    result = {word.reg_addr, word.reg_data[8]};
            default: result = word.reg_data[7:0];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_if.sv
// Byte-command / byte-response link between the sequencer and the I2C byte engine.
interface codec_cfg_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_start;
    logic       cmd_stop;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_nack;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );

endinterface

// File: rtl/codec_cfg_rom.sv
// Combinational lookup of one configuration word from the shared codec table.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0] index_i,
    output cfg_word_t  word_o
);

    assign word_o = CFG_TABLE[index_i];

endmodule

// File: rtl/codec_cfg_sequencer.sv
// Walks the codec register table, sending each word as a three-byte I2C write
// with per-word NACK retries and an idle gap between transactions.
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         NUM_REGS   = 8,
    parameter logic [6:0] DEV_ADDR   = DEV_ADDR_DEFAULT,
    parameter int         MAX_RETRY  = 3,
    parameter int         GAP_CYCLES = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    codec_cfg_sequencer_if.master        bus,
    output logic                         busy,
    output logic                         config_done,
    output logic                         config_error,
    output logic [3:0]                   err_index
);

    localparam int GAP_EFF     = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W       = $clog2(GAP_EFF + 1);
    localparam int RETRY_W_RAW = $clog2(MAX_RETRY + 1);
    localparam int RETRY_W     = (RETRY_W_RAW < 1) ? 1 : RETRY_W_RAW;

    localparam logic [3:0]         LAST_INDEX = 4'(NUM_REGS - 1);
    localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_EFF - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);

    if (NUM_REGS < 1 || NUM_REGS > 16) begin : g_bad_num_regs
        $error("codec_cfg_sequencer: NUM_REGS must be between 1 and 16");
    end

    state_t             state_q;
    logic [3:0]         index_q;
    logic [1:0]         byte_q;
    logic [1:0]         byte_d;
    logic [RETRY_W-1:0] retry_q;
    logic [GAP_W-1:0]   gap_cnt_q;
    logic               cmd_start_q;
    logic               cmd_stop_q;
    logic [7:0]         cmd_data_q;
    logic               config_done_q;
    logic               config_error_q;
    logic [3:0]         err_index_q;
    cfg_word_t          cur_word;

    codec_cfg_rom u_rom (
        .index_i (index_q),
        .word_o  (cur_word)
    );

    assign byte_d = byte_q + 2'd1;

    // The command byte is loaded on the edge that enters ISSUE so it stays put until accepted;
    // index returns to 0 on the way back to IDLE so the ROM already points at word 0 for the next pass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            index_q        <= 4'd0;
            byte_q         <= 2'd0;
            retry_q        <= '0;
            gap_cnt_q      <= '0;
            cmd_start_q    <= 1'b0;
            cmd_stop_q     <= 1'b0;
            cmd_data_q     <= 8'h00;
            config_done_q  <= 1'b0;
            config_error_q <= 1'b0;
            err_index_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q        <= ISSUE;
                        index_q        <= 4'd0;
                        byte_q         <= 2'd0;
                        retry_q        <= '0;
                        config_done_q  <= 1'b0;
                        config_error_q <= 1'b0;
                        err_index_q    <= 4'd0;
                        cmd_start_q    <= 1'b1;
                        cmd_stop_q     <= 1'b0;
                        cmd_data_q     <= cfg_byte(DEV_ADDR, cur_word, 2'd0);
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        state_q     <= WAIT_RSP;
                        cmd_start_q <= 1'b0;
                        cmd_stop_q  <= 1'b0;
                        cmd_data_q  <= 8'h00;
                    end
                end
                WAIT_RSP: begin
                    if (bus.rsp_valid) begin
                        if (!bus.rsp_nack) begin
                            if (byte_q != 2'd2) begin
                                state_q     <= ISSUE;
                                byte_q      <= byte_d;
                                cmd_start_q <= 1'b0;
                                cmd_stop_q  <= (byte_d == 2'd2);
                                cmd_data_q  <= cfg_byte(DEV_ADDR, cur_word, byte_d);
                            end else if (index_q == LAST_INDEX) begin
                                state_q       <= DONE;
                                config_done_q <= 1'b1;
                            end else begin
                                state_q   <= GAP;
                                index_q   <= index_q + 4'd1;
                                byte_q    <= 2'd0;
                                retry_q   <= '0;
                                gap_cnt_q <= '0;
                            end
                        end else if (retry_q < RETRY_MAX) begin
                            state_q   <= GAP;
                            retry_q   <= retry_q + RETRY_W'(1);
                            byte_q    <= 2'd0;
                            gap_cnt_q <= '0;
                        end else begin
                            state_q        <= ERROR;
                            config_error_q <= 1'b1;
                            err_index_q    <= index_q;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q     <= ISSUE;
                        cmd_start_q <= 1'b1;
                        cmd_stop_q  <= 1'b0;
                        cmd_data_q  <= cfg_byte(DEV_ADDR, cur_word, 2'd0);
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GAP_W'(1);
                    end
                end
                DONE, ERROR: begin
                    state_q <= IDLE;
                    index_q <= 4'd0;
                    byte_q  <= 2'd0;
                    retry_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = (state_q == ISSUE);
    assign bus.cmd_start = cmd_start_q;
    assign bus.cmd_stop  = cmd_stop_q;
    assign bus.cmd_data  = cmd_data_q;
    assign busy          = (state_q == ISSUE) || (state_q == WAIT_RSP) || (state_q == GAP);
    assign config_done   = config_done_q;
    assign config_error  = config_error_q;
    assign err_index     = err_index_q;

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// Directed bench: a scripted byte engine answers the sequencer while the main
// thread runs nominal, backpressure, NACK, reset and start-while-busy passes.
module tb_codec_cfg_sequencer;

    localparam int NUM_REGS   = 8;
    localparam int MAX_RETRY  = 3;
    localparam int GAP_CYCLES = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy;
    logic       config_done;
    logic       config_error;
    logic [3:0] err_index;

    codec_cfg_sequencer_if bus();

    codec_cfg_sequencer #(
        .NUM_REGS   (NUM_REGS),
        .DEV_ADDR   (7'h1A),
        .MAX_RETRY  (MAX_RETRY),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .busy         (busy),
        .config_done  (config_done),
        .config_error (config_error),
        .err_index    (err_index)
    );

    always #5 clk = ~clk;

    // Hand-computed words of the default table; bytes are {start, stop, data}.
    logic [15:0] expWords [0:7] = '{16'h1E00, 16'h0C10, 16'h0812, 16'h0A00,
                                    16'h0E0A, 16'h1000, 16'h0579, 16'h1201};

    int testsRun  = 0;
    int failCount = 0;

    int nackWord  = -1;
    int nackByte  = 0;
    int nackTimes = 0;
    int stallWord = -1;
    int stallByte = 0;
    int stallLen  = 0;
    int holdWord  = -1;
    int holdByte  = 0;
    int strayReq  = 0;

    logic [9:0] accQ [$];
    int         gapQ [$];
    logic [9:0] expQ [$];
    int         wordIdx = 0;
    int         lastPos = 0;
    int         pendPos = 0;
    int         pos = 0;
    bit         respDue = 0;
    bit         respNack = 0;
    bit         measuring = 0;
    int         idleCount = 0;
    bit         stallActive = 0;
    bit         stallDone = 0;
    int         stallLeft = 0;
    int         stallSeen = 0;
    int         stallViolations = 0;
    logic [7:0] stallData = 8'h00;
    int         nacksGiven = 0;
    bit         heldRsp = 0;
    int         strayDone = 0;

    // Byte engine model: accepts on the negedge it sees cmd_valid, answers on the next negedge.
    initial begin : engine
        bus.cmd_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_nack  = 1'b0;
        forever begin
            @(negedge clk);
            if (start && !busy) begin
                accQ.delete();
                gapQ.delete();
                wordIdx = 0; lastPos = 0; respDue = 0; measuring = 0;
                stallActive = 0; stallDone = 0; stallSeen = 0; stallViolations = 0;
                nacksGiven = 0; heldRsp = 0;
            end
            if (measuring) begin
                if (bus.cmd_valid) begin
                    measuring = 0;
                    if (idleCount > 0) gapQ.push_back(idleCount);
                end else if (!busy) begin
                    measuring = 0;
                end else begin
                    idleCount++;
                end
            end
            bus.rsp_valid = respDue;
            bus.rsp_nack  = respDue && respNack;
            if (strayReq != strayDone) begin
                bus.rsp_valid = 1'b1;
                bus.rsp_nack  = 1'b0;
                strayDone++;
            end
            if (respDue) begin
                measuring = 1;
                idleCount = 0;
                if (!respNack && pendPos == 2) wordIdx++;
            end
            respDue = 0;
            bus.cmd_ready = 1'b0;
            if (bus.cmd_valid) begin
                pos = bus.cmd_start ? 0 : lastPos + 1;
                if (!stallDone && !stallActive && wordIdx == stallWord && pos == stallByte) begin
                    stallActive = 1;
                    stallLeft   = stallLen;
                    stallData   = bus.cmd_data;
                end
                if (stallActive && stallLeft > 0) begin
                    if (bus.cmd_data != stallData) stallViolations++;
                    stallSeen++;
                    stallLeft--;
                end else begin
                    if (stallActive) begin
                        stallActive = 0;
                        stallDone   = 1;
                        if (bus.cmd_data != stallData) stallViolations++;
                    end
                    bus.cmd_ready = 1'b1;
                    accQ.push_back({bus.cmd_start, bus.cmd_stop, bus.cmd_data});
                    lastPos  = pos;
                    pendPos  = pos;
                    respNack = (wordIdx == nackWord && pos == nackByte && nacksGiven < nackTimes);
                    if (respNack) nacksGiven++;
                    if (wordIdx == holdWord && pos == holdByte) heldRsp = 1;
                    else respDue = 1;
                end
            end else if (stallActive) begin
                stallViolations++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int nw, input int nb, input int nt,
                                 input int sw, input int sb, input int sl,
                                 input int hw, input int hb);
        nackWord = nw; nackByte = nb; nackTimes = nt;
        stallWord = sw; stallByte = sb; stallLen = sl;
        holdWord = hw; holdByte = hb;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    function automatic logic [9:0] expByte(input int w, input int b);
        logic [15:0] word;
        word = expWords[w];
        if (b == 0) return {2'b10, 8'h34};
        if (b == 1) return {2'b00, word[15:8]};
        return {2'b01, word[7:0]};
    endfunction

    task automatic buildExpected(input int nw, input int nb, input int nt, output int nGaps);
        int  attempt;
        bit  wordOk;
        bit  nacked;
        bit  failed;
        expQ.delete();
        nGaps  = 0;
        failed = 0;
        for (int w = 0; w < NUM_REGS && !failed; w++) begin
            attempt = 0;
            wordOk  = 0;
            while (!wordOk && !failed) begin
                nacked = 0;
                for (int b = 0; b < 3 && !nacked; b++) begin
                    expQ.push_back(expByte(w, b));
                    if (w == nw && b == nb && attempt < nt) nacked = 1;
                end
                if (!nacked) wordOk = 1;
                else if (attempt == MAX_RETRY) failed = 1;
                else begin
                    attempt++;
                    nGaps++;
                end
            end
            if (!failed && w != NUM_REGS - 1) nGaps++;
        end
    endtask

    task automatic checkSequence(input string tag, input int nw, input int nb, input int nt);
        int nGaps;
        int n;
        buildExpected(nw, nb, nt, nGaps);
        checkOutput({tag, " byte count"}, accQ.size(), expQ.size());
        n = (accQ.size() < expQ.size()) ? accQ.size() : expQ.size();
        for (int i = 0; i < n; i++)
            checkOutput($sformatf("%s byte%0d", tag, i), accQ[i], expQ[i]);
        checkOutput({tag, " gap count"}, gapQ.size(), nGaps);
        for (int i = 0; i < gapQ.size(); i++)
            checkOutput($sformatf("%s gap%0d length", tag, i), gapQ[i], GAP_CYCLES);
    endtask

    task automatic waitPassEnd(input string tag);
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk); #2;
            cyc++;
        end while ((busy || !(config_done || config_error)) && cyc < 3000);
        checkOutput({tag, " pass ends in time"}, (cyc < 3000), 1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " cmd_valid"}, bus.cmd_valid, 0);
        checkOutput({tag, " cmd_start"}, bus.cmd_start, 0);
        checkOutput({tag, " cmd_stop"}, bus.cmd_stop, 0);
        checkOutput({tag, " cmd_data"}, bus.cmd_data, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " config_done"}, config_done, 0);
        checkOutput({tag, " config_error"}, config_error, 0);
        checkOutput({tag, " err_index"}, err_index, 0);
    endtask

    task automatic checkFlags(input string tag, input logic done, input logic err, input logic [3:0] idx);
        checkOutput({tag, " config_done"}, config_done, done);
        checkOutput({tag, " config_error"}, config_error, err);
        checkOutput({tag, " err_index"}, err_index, idx);
        checkOutput({tag, " busy"}, busy, 0);
    endtask

    initial begin : main
        int cyc;
        int activeSeen;

        repeat (3) @(posedge clk);
        #2 checkResetOutputs("reset");
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 checkOutput("idle after reset busy", busy, 0);

        $display("[TB] nominal pass");
        applyStimulus(-1, 0, 0, -1, 0, 0, -1, 0);
        waitPassEnd("nominal");
        checkSequence("nominal", -1, 0, 0);
        checkFlags("nominal", 1'b1, 1'b0, 4'd0);
        repeat (20) @(posedge clk);
        #2 checkOutput("nominal done sticky", config_done, 1);

        $display("[TB] backpressure on word 2 byte 1");
        applyStimulus(-1, 0, 0, 2, 1, 5, -1, 0);
        waitPassEnd("stall");
        checkSequence("stall", -1, 0, 0);
        checkOutput("stall cycles held", stallSeen, 5);
        checkOutput("stall valid/data stable", stallViolations, 0);
        checkFlags("stall", 1'b1, 1'b0, 4'd0);

        $display("[TB] single NACK on word 3 byte 1");
        applyStimulus(3, 1, 1, -1, 0, 0, -1, 0);
        waitPassEnd("nack1");
        checkSequence("nack1", 3, 1, 1);
        checkFlags("nack1", 1'b1, 1'b0, 4'd0);

        $display("[TB] persistent NACK on word 5 byte 0");
        applyStimulus(5, 0, 100, -1, 0, 0, -1, 0);
        waitPassEnd("nackall");
        checkSequence("nackall", 5, 0, 100);
        checkFlags("nackall", 1'b0, 1'b1, 4'd5);
        activeSeen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            if (bus.cmd_valid || busy) activeSeen++;
        end
        checkOutput("nackall quiet after error", activeSeen, 0);
        checkOutput("nackall error sticky", config_error, 1);

        $display("[TB] reset during WAIT_RSP of word 2");
        applyStimulus(-1, 0, 0, -1, 0, 0, 2, 1);
        #1 checkOutput("start clears config_error", config_error, 0);
        checkOutput("start clears err_index", err_index, 0);
        cyc = 0;
        while (!heldRsp && cyc < 1000) begin
            @(posedge clk); #2;
            cyc++;
        end
        checkOutput("reached word 2 WAIT_RSP", heldRsp, 1);
        checkOutput("busy before reset", busy, 1);
        #1 reset_n = 1'b0;
        #1 checkResetOutputs("async reset");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #2 strayReq = strayReq + 1;
        activeSeen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #2;
            if (bus.cmd_valid || busy) activeSeen++;
        end
        checkOutput("stays idle after reset", activeSeen, 0);
        checkOutput("stray rsp consumed", strayDone, strayReq);
        applyStimulus(-1, 0, 0, -1, 0, 0, -1, 0);
        waitPassEnd("post-reset");
        checkSequence("post-reset", -1, 0, 0);
        checkFlags("post-reset", 1'b1, 1'b0, 4'd0);

        $display("[TB] start pulse while busy during word 4");
        applyStimulus(-1, 0, 0, -1, 0, 0, -1, 0);
        cyc = 0;
        while (wordIdx < 4 && cyc < 1000) begin
            @(posedge clk); #2;
            cyc++;
        end
        checkOutput("reached word 4", (wordIdx == 4), 1);
        checkOutput("busy at stray start", busy, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        waitPassEnd("busy-start");
        checkSequence("busy-start", -1, 0, 0);
        checkFlags("busy-start", 1'b1, 1'b0, 4'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
